sync_period_scheduler: RTL

Controller that sequences the testing sync generator from the 32-bit software-written sync_period_sel control word. It arms, starts, times and stops a periodic sync pulse train, either immediately or on an external trigger, in continuous or one-shot mode. It sits in the user_clk domain between the software register output (user_data_out) and the downstream sync consumers, and reports status back for a readback register.

---
 rtl/sync_sched_pkg.sv | 8 +
 rtl/sync_period_scheduler_edge_sync.sv | 18 +
 rtl/sync_period_scheduler.sv | 83 ++++++++
 3 files changed

// File: rtl/sync_sched_pkg.sv
// sync_sched_pkg: shared state type and cfg_word bit positions for the sync period scheduler
package sync_sched_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_EXT, RUN} state_t;
    localparam int ARM_BIT     = 31;
    localparam int STOP_BIT    = 30;
    localparam int ONESHOT_BIT = 29;
    localparam int EXTMODE_BIT = 28;
endpackage

// File: rtl/sync_period_scheduler_edge_sync.sv
// sync_edge_sync: two-flop synchroniser followed by a rising-edge detector
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   rise  : one-cycle strobe when the synchronised input goes 0 -> 1
module sync_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [2:0] sr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else        sr <= {sr[1:0], d};
    // sr[1] is the second synchroniser flop, sr[2] its previous value
    assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/sync_period_scheduler.sv
// sync_period_scheduler: arms, starts, times and stops a periodic sync pulse train from cfg_word
//   user_clk    : clock
//   user_rst_n  : asynchronous active-low reset
//   cfg_word    : [31] arm (rising edge), [30] stop, [29] one_shot, [28] ext_mode, [PERIOD_W-1:0] period_m1
//   ext_sync_in : asynchronous external start trigger
//   sync_out    : SYNC_WIDTH-cycle pulse every period_m1+1 cycles
//   sync_cnt    : pulses issued since the last accepted arm
//   running     : high while waiting for the trigger or running
//   cfg_err     : last arm was rejected because the period was too short
module sync_period_scheduler
    import sync_sched_pkg::*;
#(
    parameter int PERIOD_W   = 28,
    parameter int SYNC_WIDTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    input  logic [31:0]      cfg_word,
    input  logic             ext_sync_in,
    output logic             sync_out,
    output logic [CNT_W-1:0] sync_cnt,
    output logic             running,
    output logic             cfg_err
);
    state_t state, state_n;
    logic arm_q, ext_rise, stop, arm_rise, arm_ok, wrap, start, os_sh, sync_out_n;
    logic [PERIOD_W-1:0] p_sh, cnt, cnt_n;
    logic [CNT_W-1:0] sync_cnt_n;

    sync_edge_sync u_ext (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .d     (ext_sync_in),
        .rise  (ext_rise)
    );

    // stop masks arm entirely, so an arm+stop cycle neither starts nor flags an error
    assign stop     = cfg_word[STOP_BIT];
    assign arm_rise = cfg_word[ARM_BIT] & ~arm_q & ~stop;
    assign arm_ok   = arm_rise & (cfg_word[PERIOD_W-1:0] >= PERIOD_W'(SYNC_WIDTH));
    assign wrap     = cnt == p_sh;
    assign running  = state != IDLE;

    always_ff @(posedge user_clk or negedge user_rst_n)
        if (!user_rst_n) begin
            state    <= IDLE;
            arm_q    <= 1'b0;
            cnt      <= '0;
            sync_out <= 1'b0;
            sync_cnt <= '0;
            cfg_err  <= 1'b0;
            p_sh     <= '0;
            os_sh    <= 1'b0;
        end else begin
            state    <= state_n;
            arm_q    <= cfg_word[ARM_BIT];
            cnt      <= cnt_n;
            sync_out <= sync_out_n;
            sync_cnt <= sync_cnt_n;
            if (arm_rise) cfg_err <= ~arm_ok;
            if (arm_ok) begin
                p_sh  <= cfg_word[PERIOD_W-1:0];
                os_sh <= cfg_word[ONESHOT_BIT];
            end
        end

    always_comb begin
        state_n = state;
        if (stop)                          state_n = IDLE;
        else if (arm_ok)                   state_n = cfg_word[EXTMODE_BIT] ? WAIT_EXT : RUN;
        else if (state == WAIT_EXT && ext_rise) state_n = RUN;
        else if (state == RUN && wrap && os_sh) state_n = IDLE;
    end

    // start marks the cycle before a pulse's first high cycle: the counter restarts at 0
    always_comb begin
        start      = state_n == RUN && (state != RUN || arm_ok || wrap);
        cnt_n      = (start || state_n != RUN) ? '0 : cnt + PERIOD_W'(1);
        sync_out_n = state_n == RUN && cnt_n < PERIOD_W'(SYNC_WIDTH);
        sync_cnt_n = (arm_ok ? '0 : sync_cnt) + CNT_W'(start);
    end
endmodule
